prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker_pkg.sv | 20 ++
 rtl/prbs_checker_if.sv | 40 ++++
 rtl/prbs_lfsr_step.sv | 14 +
 rtl/prbs_checker.sv | 139 +++++++++++++
 tb/tb_prbs_checker.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: default generator polynomial and the lock-state
// enumeration used by both the upstream Galois generator and the checker.
package prbs_checker_pkg;

  localparam int PRBS_LN = 8;
  localparam logic [PRBS_LN-1:0] PRBS_TAPS = 8'h2D;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbsState_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Received-bit stream, statistics clear and lock/statistics status of the PRBS checker.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);

  logic             inBit__ENA;
  logic             inBit_v;
  logic             inBit__RDY;
  logic             clear__ENA;
  logic             clear__RDY;
  logic             locked;
  logic [CNT_W-1:0] bitCount;
  logic [CNT_W-1:0] errCount;
  logic [7:0]       lossCount;

  modport master (
    output inBit__ENA,
    output inBit_v,
    output clear__ENA,
    input  inBit__RDY,
    input  clear__RDY,
    input  locked,
    input  bitCount,
    input  errCount,
    input  lossCount
  );

  modport slave (
    input  inBit__ENA,
    input  inBit_v,
    input  clear__ENA,
    output inBit__RDY,
    output clear__RDY,
    output locked,
    output bitCount,
    output errCount,
    output lossCount
  );

endinterface

// File: rtl/prbs_lfsr_step.sv
// One Galois LFSR step: shift right, insert the feedback bit at the top and
// fold the tap mask in whenever the feedback bit is set.
module prbs_lfsr_step #(
    parameter int            LN   = 8,
    parameter logic [LN-1:0] TAPS = 8'h2D
) (
    input  logic [LN-1:0] cs,
    input  logic          fb,
    output logic [LN-1:0] csNext
);

  assign csNext = {fb, cs[LN-1:1]} ^ (fb ? TAPS : {LN{1'b0}});

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises a local Galois model to the received stream,
// verifies it, then counts checked bits, bit errors and losses of lock.
module prbs_checker
  import prbs_checker_pkg::*;
#(
    parameter int            LN         = PRBS_LN,
    parameter logic [LN-1:0] TAPS       = PRBS_TAPS,
    parameter int            LOCK_CNT   = 16,
    parameter int            UNLOCK_ERR = 4,
    parameter int            CNT_W      = 16
) (
    input logic          CLK,
    input logic          RST,
    prbs_checker_if.slave bus
);

  localparam int RUN_W = $clog2(maxOf3(LN, LOCK_CNT, UNLOCK_ERR) + 1);
  localparam logic [RUN_W-1:0] HUNT_LAST   = RUN_W'(LN - 1);
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_ERR - 1);
  localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

  prbsState_t       state, stateNext;
  logic [LN-1:0]    cs, csNext, csStep;
  logic [RUN_W-1:0] run, runNext;
  logic [CNT_W-1:0] bitCnt, bitCntNext;
  logic [CNT_W-1:0] errCnt, errCntNext;
  logic [7:0]       lossCnt, lossCntNext;
  logic             fb;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] satIncLoss(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // While hunting the model follows the line; afterwards it free-runs so line
  // errors cannot corrupt it.
  assign fb       = (state == HUNT) ? bus.inBit_v : cs[0];
  assign mismatch = bus.inBit_v ^ cs[0];

  prbs_lfsr_step #(
    .LN  (LN),
    .TAPS(TAPS)
  ) u_step (
    .cs    (cs),
    .fb    (fb),
    .csNext(csStep)
  );

  always_comb begin
    stateNext   = state;
    csNext      = cs;
    runNext     = run;
    bitCntNext  = bitCnt;
    errCntNext  = errCnt;
    lossCntNext = lossCnt;

    if (bus.inBit__ENA) begin
      csNext = csStep;
      case (state)
        HUNT: begin
          if (run == HUNT_LAST) begin
            stateNext = VERIFY;
            runNext   = '0;
          end else begin
            runNext = run + RUN_ONE;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            stateNext = HUNT;
            runNext   = '0;
          end else if (run == LOCK_LAST) begin
            stateNext = LOCKED;
            runNext   = '0;
          end else begin
            runNext = run + RUN_ONE;
          end
        end
        LOCKED: begin
          bitCntNext = satIncCnt(bitCnt);
          if (mismatch) begin
            errCntNext = satIncCnt(errCnt);
            if (run == UNLOCK_LAST) begin
              stateNext   = HUNT;
              runNext     = '0;
              lossCntNext = satIncLoss(lossCnt);
            end else begin
              runNext = run + RUN_ONE;
            end
          end else begin
            runNext = '0;
          end
        end
        default: begin
          stateNext = HUNT;
          runNext   = '0;
        end
      endcase
    end

    // Clearing the statistics beats any increment in the same cycle.
    if (bus.clear__ENA) begin
      bitCntNext  = '0;
      errCntNext  = '0;
      lossCntNext = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= HUNT;
      cs      <= '0;
      run     <= '0;
      bitCnt  <= '0;
      errCnt  <= '0;
      lossCnt <= '0;
    end else begin
      state   <= stateNext;
      cs      <= csNext;
      run     <= runNext;
      bitCnt  <= bitCntNext;
      errCnt  <= errCntNext;
      lossCnt <= lossCntNext;
    end
  end

  assign bus.inBit__RDY = 1'b1;
  assign bus.clear__RDY = 1'b1;
  assign bus.locked     = (state == LOCKED);
  assign bus.bitCount   = bitCnt;
  assign bus.errCount   = errCnt;
  assign bus.lossCount  = lossCnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker driven by a reference Galois generator
// (LN=8, taps 0x2D, feedback = output bit).
module tb_prbs_checker;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;
  logic [7:0] g;

  prbs_checker_if #(.CNT_W(16)) bus ();

  prbs_checker #(
    .LN        (8),
    .TAPS      (8'h2D),
    .LOCK_CNT  (16),
    .UNLOCK_ERR(4),
    .CNT_W     (16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic nextGen(output logic b);
    b = g[0];
    g = {b, g[7:1]} ^ (b ? 8'h2D : 8'h00);
  endtask

  task automatic sendBit(input logic v, input logic ena, input logic clr);
    @(negedge CLK);
    bus.inBit_v    = v;
    bus.inBit__ENA = ena;
    bus.clear__ENA = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset(input logic ena, input logic clr);
    @(negedge CLK);
    RST            = 1'b1;
    bus.inBit_v    = 1'b1;
    bus.inBit__ENA = ena;
    bus.clear__ENA = clr;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST            = 1'b0;
    bus.inBit__ENA = 1'b0;
    bus.clear__ENA = 1'b0;
  endtask

  // Feeds correct generator bits until locked; n = bits fed, 0 if no lock in 100.
  task automatic lockUp(output int n);
    logic b;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      nextGen(b);
      sendBit(b, 1'b1, 1'b0);
      if (bus.locked) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic b;
    int   n;
    int   lockAt;
    int   accepted;
    logic ena;

    vectors        = 0;
    miscompares    = 0;
    RST            = 1'b0;
    bus.inBit__ENA = 1'b0;
    bus.inBit_v    = 1'b0;
    bus.clear__ENA = 1'b0;
    g              = 8'h01;

    doReset(1'b1, 1'b1);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_bitCount", int'(bus.bitCount), 0);
    chk("rst_errCount", int'(bus.errCount), 0);
    chk("rst_lossCount", int'(bus.lossCount), 0);
    chk("inBit_rdy", int'(bus.inBit__RDY), 1);
    chk("clear_rdy", int'(bus.clear__RDY), 1);

    // Clean stream from seed 0x01: lock after LN+LOCK_CNT = 24 bits.
    lockUp(n);
    chk("first_lock_at", n, 24);
    for (int i = 0; i < 6; i++) begin
      nextGen(b);
      sendBit(b, 1'b1, 1'b0);
    end
    chk("clean_bitCount", int'(bus.bitCount), 6);
    chk("clean_errCount", int'(bus.errCount), 0);

    // Single inverted bit while locked.
    nextGen(b);
    sendBit(~b, 1'b1, 1'b0);
    chk("single_err_errCount", int'(bus.errCount), 1);
    chk("single_err_locked", int'(bus.locked), 1);
    nextGen(b);
    sendBit(b, 1'b1, 1'b0);
    chk("after_err_errCount", int'(bus.errCount), 1);
    chk("after_err_bitCount", int'(bus.bitCount), 8);

    // Clear together with a mismatch leaves everything zero.
    nextGen(b);
    sendBit(~b, 1'b1, 1'b1);
    chk("clear_errCount", int'(bus.errCount), 0);
    chk("clear_bitCount", int'(bus.bitCount), 0);
    nextGen(b);
    sendBit(b, 1'b1, 1'b0);
    chk("post_clear_bitCount", int'(bus.bitCount), 1);

    // Idle cycle with garbage on the data line changes nothing.
    sendBit(1'b1, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    chk("gap_bitCount", int'(bus.bitCount), 1);
    chk("gap_errCount", int'(bus.errCount), 0);

    // Four consecutive errors: lock held for three, lost on the fourth.
    for (int i = 0; i < 3; i++) begin
      nextGen(b);
      sendBit(~b, 1'b1, 1'b0);
    end
    chk("three_err_locked", int'(bus.locked), 1);
    chk("three_err_lossCount", int'(bus.lossCount), 0);
    nextGen(b);
    sendBit(~b, 1'b1, 1'b0);
    chk("four_err_locked", int'(bus.locked), 0);
    chk("four_err_lossCount", int'(bus.lossCount), 1);
    chk("four_err_errCount", int'(bus.errCount), 4);
    chk("four_err_bitCount", int'(bus.bitCount), 5);
    lockUp(n);
    chk("relock_at", n, 24);

    // Reset while locked with nonzero counters.
    nextGen(b);
    sendBit(b, 1'b1, 1'b0);
    nextGen(b);
    sendBit(~b, 1'b1, 1'b0);
    chk("pre_rst_errCount", int'(bus.errCount), 5);
    doReset(1'b1, 1'b0);
    chk("midlock_rst_locked", int'(bus.locked), 0);
    chk("midlock_rst_bitCount", int'(bus.bitCount), 0);
    chk("midlock_rst_errCount", int'(bus.errCount), 0);
    chk("midlock_rst_lossCount", int'(bus.lossCount), 0);

    // Error during VERIFY on bit 12: back to HUNT, lock on bit 36.
    g      = 8'h01;
    lockAt = 0;
    for (int i = 1; i <= 60; i++) begin
      nextGen(b);
      sendBit((i == 12) ? ~b : b, 1'b1, 1'b0);
      if (bus.locked && lockAt == 0) lockAt = i;
    end
    chk("verify_err_lock_at", lockAt, 36);
    chk("verify_err_lossCount", int'(bus.lossCount), 0);

    // All-zero stream is a legal sequence.
    doReset(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) sendBit(1'b0, 1'b1, 1'b0);
    chk("zero_locked", int'(bus.locked), 1);
    chk("zero_errCount", int'(bus.errCount), 0);
    chk("zero_bitCount", int'(bus.bitCount), 16);

    // 50% enable gaps: lock point in accepted bits unchanged.
    doReset(1'b0, 1'b0);
    g        = 8'h01;
    accepted = 0;
    lockAt   = 0;
    for (int c = 0; c < 400 && lockAt == 0; c++) begin
      ena = 1'($urandom_range(0, 1));
      if (ena) begin
        nextGen(b);
        accepted++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      sendBit(b, ena, 1'b0);
      if (bus.locked) lockAt = accepted;
    end
    chk("gapped_lock_at", lockAt, 24);

    // 256 losses of lock: lossCount saturates at 255.
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 4; i++) begin
        nextGen(b);
        sendBit(~b, 1'b1, 1'b0);
      end
      lockUp(n);
    end
    chk("sat_lossCount", int'(bus.lossCount), 255);
    chk("sat_relock", int'(bus.locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
